// File: rtl/uart_tx_arb_pkg.sv
// ============================================================================
// Module : uart_tx_arb_pkg
// Brief  : Shared types and defaults for the UART TX round-robin arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_tx_arb_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_STROBE_CYC  = 4;
  localparam int DEF_GAP_CYC     = 16;
  localparam int DEF_TIMEOUT_CYC = 65535;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_STROBE     = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_GAP        = 3'd4
  } state_e;

  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker: first request at or after ptr_i.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] sel_oh_o,
  output logic [IDX_W-1:0]   sel_idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    w_cand    = '0;
    sel_idx_o = '0;
    sel_oh_o  = '0;
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
      if (req_i[w_cand]) begin
        sel_idx_o = w_cand;
      end
    end
    valid_o = |req_i;
    if (valid_o) begin
      sel_oh_o[sel_idx_o] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Round-robin sharing of one UART transmitter among NUM_REQ sources.
//          Define UART_TX_ARB_TIMEOUT_EN to add the bps_start watchdog.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int STROBE_CYC  = DEF_STROBE_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_int,
  input  logic                      bps_start,
  output logic                      busy,
  output logic                      timeout
);

  localparam int PW      = $clog2(NUM_REQ);
  localparam int CNT_LIM = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
  localparam int CNT_W   = cnt_width(CNT_LIM);

  state_e              state_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [BYTE_W-1:0]   tx_data_q;
  logic                tx_int_q;
  logic                busy_q;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       ptr_d;
  logic [CNT_W-1:0]    cnt_q;

  logic [BYTE_W-1:0]   w_bytes [NUM_REQ];
  logic [NUM_REQ-1:0]  w_sel_oh;
  logic [PW-1:0]       w_sel_idx;
  logic                w_sel_vld;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_bytes[i] = req_data[BYTE_W*i +: BYTE_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (PW)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .sel_oh_o  (w_sel_oh),
    .sel_idx_o (w_sel_idx),
    .valid_o   (w_sel_vld)
  );

  assign ptr_d = (w_sel_idx == PW'(NUM_REQ - 1)) ? '0 : w_sel_idx + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int WD_W = cnt_width(TIMEOUT_CYC);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ack_q     <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      tx_int_q  <= 1'b1;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (w_sel_vld) begin
            grant_q   <= w_sel_oh;
            ack_q     <= w_sel_oh;
            tx_data_q <= w_bytes[w_sel_idx];
            ptr_q     <= ptr_d;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (cnt_q == CNT_W'(STROBE_CYC)) begin
            tx_int_q <= 1'b1;
            state_q  <= ST_WAIT_START;
          end else begin
            tx_int_q <= 1'b0;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        ST_WAIT_START: begin
          if (bps_start) begin
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!bps_start) begin
            grant_q <= '0;
            cnt_q   <= '0;
            if (GAP_CYC == 0) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          grant_q  <= '0;
          tx_int_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
      // Watchdog overrides the normal wait transitions when it expires.
      timeout_q <= 1'b0;
      if (state_q == ST_WAIT_START || state_q == ST_WAIT_DONE) begin
        if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          wd_q      <= '0;
          timeout_q <= 1'b1;
          tx_int_q  <= 1'b1;
          grant_q   <= '0;
          cnt_q     <= '0;
          busy_q    <= (GAP_CYC != 0);
          state_q   <= (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
      end else begin
        wd_q <= '0;
      end
`endif
    end
  end

  assign ack     = ack_q;
  assign grant   = grant_q;
  assign tx_data = tx_data_q;
  assign tx_int  = tx_int_q;
  assign busy    = busy_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  // Without the watchdog the limit is kept only so both builds share one interface.
  localparam logic UNUSED_TIMEOUT = (TIMEOUT_CYC != 0);
  assign timeout = 1'b0 & UNUSED_TIMEOUT;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Scoreboard bench for uart_tx_arbiter with a simple transmitter model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        bps_start = 1'b0;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_int;
  logic        busy;
  logic        timeout;

  typedef struct packed {
    logic [3:0] oh;
    logic [7:0] data;
  } exp_t;

  exp_t       sbq[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_data = '0;
  bit         model_en = 1'b1;
  int         frame_len = 50;

  always #10 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .STROBE_CYC  (4),
    .GAP_CYC     (16),
    .TIMEOUT_CYC (200)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .grant     (grant),
    .tx_data   (tx_data),
    .tx_int    (tx_int),
    .bps_start (bps_start),
    .busy      (busy),
    .timeout   (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] oh, input logic [7:0] data);
    exp_t e;
    e.oh   = oh;
    e.data = data;
    sbq.push_back(e);
  endtask

  task automatic wait_ack(output logic [3:0] a);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (ack == 4'b0 && t < 20000);
    if (ack == 4'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_ack: got no ack within %0d cycles, expected a pulse", t);
    end
    a = ack;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 20000);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, t);
    end
  endtask

  task automatic wait_bps(input logic lvl, input int budget);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (bps_start !== lvl && t < budget);
    if (bps_start !== lvl) begin
      checks++;
      errors++;
      $display("FAIL wait_bps: bps_start=%b expected %b", bps_start, lvl);
    end
  endtask

  // Transmitter model: busy 3 cycles after the strobe falls, for frame_len cycles.
  initial begin
    forever begin
      @(negedge tx_int);
      if (model_en) begin
        repeat (3) @(negedge clk);
        bps_start = 1'b1;
        repeat (frame_len) @(negedge clk);
        bps_start = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every ack and checks strobe shape.
  initial begin
    logic [3:0] prev_ack;
    int         low;
    exp_t       e;
    prev_ack = '0;
    low      = 0;
    forever begin
      @(negedge clk);
      if (prev_ack != 4'b0) chk("ack_single_cycle", {28'b0, ack}, 32'h0);
      if (ack != 4'b0) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected: got ack=%b, expected none", ack);
        end else begin
          e = sbq.pop_front();
          chk("ack_onehot", {28'b0, ack}, {28'b0, e.oh});
          chk("grant", {28'b0, grant}, {28'b0, e.oh});
          chk("tx_data", {24'b0, tx_data}, {24'b0, e.data});
          last_data = e.data;
        end
      end
      prev_ack = ack;
      if (rst_n && tx_int == 1'b0) begin
        low++;
      end else begin
        if (low > 0) begin
          chk("strobe_len", low, 4);
          chk("tx_data_held", {24'b0, tx_data}, {24'b0, last_data});
        end
        low = 0;
      end
    end
  end

  initial begin
    logic [3:0] a;
    int         cnt;
`ifdef UART_TX_ARB_TIMEOUT_EN
    bit         seen;
`endif

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_int", {31'b0, tx_int}, 32'h1);
    chk("rst_grant", {28'b0, grant}, 32'h0);
    chk("rst_ack", {28'b0, ack}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
    chk("rst_timeout", {31'b0, timeout}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_outputs", {22'b0, tx_int, grant, busy, ack}, {22'b0, 1'b1, 4'b0, 1'b0, 4'b0});
    end

    // All sources requesting: strict rotation starting at source 0.
    req_data = 32'h13121110;
    push(4'b0001, 8'h10);
    push(4'b0010, 8'h11);
    push(4'b0100, 8'h12);
    push(4'b1000, 8'h13);
    push(4'b0001, 8'h10);
    req = 4'hF;
    repeat (5) wait_ack(a);
    req = 4'h0;
    wait_idle();

    // Single source 2 with a long frame; gap measured from bps_start falling.
    frame_len = 5000;
    req_data  = 32'h00A50000;
    push(4'b0100, 8'hA5);
    req = 4'b0100;
    wait_ack(a);
    req = 4'h0;
    wait_bps(1'b1, 100);
    @(negedge clk);
    chk("frame_grant", {28'b0, grant}, 32'h4);
    chk("frame_busy", {31'b0, busy}, 32'h1);
    chk("frame_tx_data", {24'b0, tx_data}, 32'hA5);
    wait_bps(1'b0, 6000);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    chk("gap_busy_cycles", cnt, 16);
    chk("gap_grant_cleared", {28'b0, grant}, 32'h0);
    chk("gap_tx_data_kept", {24'b0, tx_data}, 32'hA5);
    frame_len = 50;

    // Pointer sits at 3: 3 then 0 (wrap), then pointer 1 picks source 1 over 0.
    req_data = 32'hD300D1D0;
    push(4'b1000, 8'hD3);
    push(4'b0001, 8'hD0);
    req = 4'b1001;
    wait_ack(a);
    req = req & ~a;
    wait_ack(a);
    req = req & ~a;
    wait_idle();
    push(4'b0010, 8'hD1);
    req = 4'b0011;
    wait_ack(a);
    req = 4'h0;
    wait_idle();

    // Reset in WAIT_DONE: outputs clear without a clock edge; pointer back to 0.
    req_data = 32'h00770000;
    push(4'b0100, 8'h77);
    req = 4'b0100;
    wait_ack(a);
    req = 4'h0;
    wait_bps(1'b1, 100);
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx_int", {31'b0, tx_int}, 32'h1);
    chk("async_rst_grant", {28'b0, grant}, 32'h0);
    chk("async_rst_busy", {31'b0, busy}, 32'h0);
    chk("async_rst_tx_data", {24'b0, tx_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_bps(1'b0, 200);
    @(negedge clk);
    req_data = 32'h44332211;
    push(4'b0001, 8'h11);
    req = 4'hF;
    wait_ack(a);
    req = 4'h0;
    wait_idle();

    // Transmitter never answers.
    model_en = 1'b0;
    req_data = 32'h00005500;
    push(4'b0010, 8'h55);
    req = 4'b0010;
    wait_ack(a);
    req = 4'h0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (timeout) begin
        seen = 1'b1;
        break;
      end
    end
    chk("timeout_pulse", {31'b0, seen}, 32'h1);
    chk("timeout_grant", {28'b0, grant}, 32'h0);
    wait_idle();
`else
    repeat (300) @(negedge clk);
    chk("stuck_busy", {31'b0, busy}, 32'h1);
    chk("stuck_timeout", {31'b0, timeout}, 32'h0);
    chk("stuck_grant", {28'b0, grant}, 32'h2);
    chk("stuck_tx_int", {31'b0, tx_int}, 32'h1);
`endif

    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
